// File: rtl/out_layer_mac.sv
`default_nettype none
// ============================================================================
//  Module   : out_layer_mac
//  Function : Final-layer MAC engine. Buffers one frame of activations, then
//             streams NN4 class scores (dot product with ROM row + bias).
//  Options  : define OUT_RELU_EN to clamp negative scores to zero.
//  Revision : 1.0  initial release
// ============================================================================
module out_layer_mac #(
    parameter int DATA_WIDTH      = 16,
    parameter int WEIGHT_WIDTH    = 16,
    parameter int ACC_WIDTH       = 47,
    parameter int NN4             = 10,
    parameter int PREVLAYER_COUNT = 10,
    parameter int ADDR_WIDTH      = 7
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           act_valid,
    input  logic signed [DATA_WIDTH-1:0]   act_data,
    output logic                           act_ready,
    output logic        [ADDR_WIDTH-1:0]   weight_addr,
    input  logic signed [WEIGHT_WIDTH-1:0] weight_data,
    output logic signed [ACC_WIDTH-1:0]    out_data,
    output logic                           out_valid,
    output logic        [3:0]              out_index,
    output logic                           out_last,
    output logic                           busy,
    output logic                           frame_done
);

    localparam int c_cnt_w  = $clog2(PREVLAYER_COUNT + 1);
    localparam int c_idx_w  = (PREVLAYER_COUNT > 1) ? $clog2(PREVLAYER_COUNT) : 1;
    localparam int c_prod_w = DATA_WIDTH + WEIGHT_WIDTH;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_MAC  = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic        [c_cnt_w-1:0]      load_cnt_q, load_cnt_d;
    logic        [c_cnt_w-1:0]      c_q, c_d;
    logic        [3:0]              n_q, n_d;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic        [ADDR_WIDTH-1:0]   weight_addr_q, weight_addr_d;
    logic signed [ACC_WIDTH-1:0]    out_data_q, out_data_d;
    logic        [3:0]              out_index_q, out_index_d;
    logic                           out_valid_q, out_valid_d;
    logic                           out_last_q, out_last_d;
    logic                           frame_done_q, frame_done_d;

    logic signed [DATA_WIDTH-1:0]   act_buf_q [PREVLAYER_COUNT];
    logic                           w_buf_we;
    logic        [c_cnt_w-1:0]      w_c_m1;
    logic signed [c_prod_w-1:0]     w_prod;
    logic signed [ACC_WIDTH-1:0]    w_sum;
    logic signed [ACC_WIDTH-1:0]    w_score;

    // ROM data lags the address by one cycle, so cycle c consumes entry c-1.
    assign w_c_m1 = c_q - c_cnt_w'(1);
    assign w_prod = act_buf_q[c_idx_w'(w_c_m1)] * weight_data;
    assign w_sum  = acc_q + ACC_WIDTH'(weight_data);

`ifdef OUT_RELU_EN
    assign w_score = w_sum[ACC_WIDTH-1] ? '0 : w_sum;
`else
    assign w_score = w_sum;
`endif

    always_comb begin
        state_d       = state_q;
        load_cnt_d    = load_cnt_q;
        c_d           = c_q;
        n_d           = n_q;
        acc_d         = acc_q;
        weight_addr_d = weight_addr_q;
        out_data_d    = out_data_q;
        out_index_d   = out_index_q;
        out_valid_d   = 1'b0;
        out_last_d    = 1'b0;
        frame_done_d  = 1'b0;
        w_buf_we      = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (act_valid) begin
                    w_buf_we = 1'b1;
                    if (load_cnt_q == c_cnt_w'(PREVLAYER_COUNT - 1)) begin
                        load_cnt_d    = '0;
                        c_d           = '0;
                        n_d           = '0;
                        acc_d         = '0;
                        weight_addr_d = '0;
                        state_d       = S_MAC;
                    end else begin
                        load_cnt_d = load_cnt_q + c_cnt_w'(1);
                    end
                end
            end
            S_MAC: begin
                if (c_q != '0) begin
                    acc_d = acc_q + ACC_WIDTH'(w_prod);
                end
                if (c_q == c_cnt_w'(PREVLAYER_COUNT)) begin
                    state_d = S_EMIT;
                end else begin
                    c_d           = c_q + c_cnt_w'(1);
                    weight_addr_d = weight_addr_q + ADDR_WIDTH'(1);
                end
            end
            S_EMIT: begin
                out_data_d  = w_score;
                out_index_d = n_q;
                out_valid_d = 1'b1;
                out_last_d  = (n_q == 4'(NN4 - 1));
                acc_d       = '0;
                c_d         = '0;
                if (n_q == 4'(NN4 - 1)) begin
                    n_d           = '0;
                    weight_addr_d = '0;
                    state_d       = S_DONE;
                end else begin
                    // Address already rests on the bias; +1 is the next row's base.
                    n_d           = n_q + 4'd1;
                    weight_addr_d = weight_addr_q + ADDR_WIDTH'(1);
                    state_d       = S_MAC;
                end
            end
            S_DONE: begin
                frame_done_d = 1'b1;
                load_cnt_d   = '0;
                state_d      = S_LOAD;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_LOAD;
            load_cnt_q    <= '0;
            c_q           <= '0;
            n_q           <= '0;
            acc_q         <= '0;
            weight_addr_q <= '0;
            out_data_q    <= '0;
            out_index_q   <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_cnt_q    <= load_cnt_d;
            c_q           <= c_d;
            n_q           <= n_d;
            acc_q         <= acc_d;
            weight_addr_q <= weight_addr_d;
            out_data_q    <= out_data_d;
            out_index_q   <= out_index_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            frame_done_q  <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            act_buf_q[c_idx_w'(load_cnt_q)] <= act_data;
        end
    end

    assign act_ready   = (state_q == S_LOAD);
    assign busy        = (state_q != S_LOAD);
    assign weight_addr = weight_addr_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_index   = out_index_q;
    assign out_last    = out_last_q;
    assign frame_done  = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_out_layer_mac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_out_layer_mac
//  Function : Self-checking bench for out_layer_mac against a frame-level
//             dot-product model (honours OUT_RELU_EN when defined).
//  Revision : 1.0  initial release
// ============================================================================
module tb_out_layer_mac;

    localparam int P      = 10;
    localparam int NN     = 10;
    localparam int PER    = P + 2;
    localparam int FRAME  = NN * PER;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               act_valid = 1'b0;
    logic signed [15:0] act_data = '0;
    logic               act_ready;
    logic        [6:0]  weight_addr;
    logic signed [15:0] weight_data;
    logic signed [46:0] out_data;
    logic               out_valid;
    logic        [3:0]  out_index;
    logic               out_last;
    logic               busy;
    logic               frame_done;

    out_layer_mac #(
        .DATA_WIDTH(16), .WEIGHT_WIDTH(16), .ACC_WIDTH(47),
        .NN4(NN), .PREVLAYER_COUNT(P), .ADDR_WIDTH(7)
    ) dut (
        .clk(clk), .reset(reset),
        .act_valid(act_valid), .act_data(act_data), .act_ready(act_ready),
        .weight_addr(weight_addr), .weight_data(weight_data),
        .out_data(out_data), .out_valid(out_valid), .out_index(out_index),
        .out_last(out_last), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic signed [15:0] rom [0:127];
    always @(posedge clk) weight_data <= rom[weight_addr];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference model: frame-level timing plus plain dot products.
    int                 cyc = 0;
    bit                 active = 1'b0;
    int                 t_start = 0;
    bit                 rst_seen = 1'b0;
    int                 m_load = 0;
    int                 frames_done = 0;
    logic signed [15:0] m_act [P];
    logic signed [46:0] m_exp [NN];
    logic signed [46:0] dut_score [NN];

    always @(negedge clk) begin
        int     rel;
        int     n;
        bit     in_frame;
        bit     ev;
        bit     ef;
        longint s;
        cyc++;
        rel      = cyc - t_start;
        in_frame = active && rel >= 0 && rel <= FRAME;
        if (rst_seen) begin
            check("rst_out_data", out_data, 0);
            check("rst_out_index", out_index, 0);
            check("rst_weight_addr", weight_addr, 0);
            rst_seen = 1'b0;
        end
        check("act_ready", act_ready, !in_frame);
        check("busy", busy, in_frame);
        ev = in_frame && rel >= PER && (rel % PER) == 0;
        n  = rel / PER - 1;
        check("out_valid", out_valid, ev);
        check("out_last", out_last, ev && n == NN - 1);
        if (ev && out_valid) begin
            check("out_index", out_index, n);
            check("out_data", out_data, m_exp[n]);
            dut_score[n] = out_data;
        end
        if (in_frame && rel < FRAME && (rel % PER) <= P)
            check("weight_addr", weight_addr, (rel / PER) * (P + 1) + (rel % PER));
        ef = active && rel == FRAME + 1;
        check("frame_done", frame_done, ef);
        if (ef) begin
            active = 1'b0;
            frames_done++;
        end
        if (reset) begin
            active   = 1'b0;
            m_load   = 0;
            rst_seen = 1'b1;
        end else if (!in_frame && act_valid) begin
            m_act[m_load] = act_data;
            m_load++;
            if (m_load == P) begin
                m_load = 0;
                for (int j = 0; j < NN; j++) begin
                    s = 0;
                    for (int k = 0; k < P; k++)
                        s += longint'(m_act[k]) * longint'(rom[j*(P+1)+k]);
                    s += longint'(rom[j*(P+1)+P]);
`ifdef OUT_RELU_EN
                    if (s < 0) s = 0;
`endif
                    m_exp[j] = s[46:0];
                end
                active  = 1'b1;
                t_start = cyc + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_scores();
        for (int j = 0; j < NN; j++) dut_score[j] = 47'sd12345;
    endtask

    task automatic rom_basic();
        for (int i = 0; i < 128; i++) rom[i] = '0;
        for (int j = 0; j < NN; j++)
            for (int k = 0; k < P; k++) rom[j*(P+1)+k] = 16'(j);
    endtask

    task automatic rom_signed();
        for (int i = 0; i < 128; i++) rom[i] = '0;
        for (int j = 0; j < NN; j++) begin
            for (int k = 0; k < P; k++) rom[j*(P+1)+k] = 16'sd2;
            rom[j*(P+1)+P] = -16'sd5;
        end
    endtask

    task automatic rom_random();
        for (int i = 0; i < 128; i++) rom[i] = 16'($urandom);
    endtask

    // mode 0: continuous constant, 1: alternating constant,
    // 2: continuous random, 3: random gaps with random data
    task automatic load_frame(input int mode, input logic signed [15:0] val);
        int sent = 0;
        while (sent < P) begin
            case (mode)
                0: begin act_valid = 1'b1; act_data = val; end
                1: begin act_valid = ~act_valid; act_data = act_valid ? val : 16'h7fff; end
                2: begin act_valid = 1'b1; act_data = 16'($urandom); end
                default: begin act_valid = ($urandom_range(0, 2) != 0); act_data = 16'($urandom); end
            endcase
            tick();
            if (act_valid) sent++;
        end
        act_valid = 1'b0;
    endtask

    task automatic wait_done();
        int  t = 0;
        bit  seen = 1'b0;
        while (!seen && t < 2 * FRAME + 50) begin
            tick();
            t++;
            seen = frame_done;
        end
        check("frame_done_timeout", seen, 1);
    endtask

    initial begin
        rom_basic();
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Basic frame: scores 0,10,...,90
        clear_scores();
        load_frame(0, 16'sd1);
        wait_done();
        check("lit_basic_0", dut_score[0], 0);
        check("lit_basic_4", dut_score[4], 40);
        check("lit_basic_9", dut_score[9], 90);
        check("lit_model_9", m_exp[9], 90);
        repeat (3) tick();

        // Signed activations and negative bias
        rom_signed();
        clear_scores();
        load_frame(0, -16'sd3);
        wait_done();
`ifdef OUT_RELU_EN
        check("lit_signed_0", dut_score[0], 0);
        check("lit_signed_9", dut_score[9], 0);
`else
        check("lit_signed_0", dut_score[0], -65);
        check("lit_signed_9", dut_score[9], -65);
`endif
        repeat (2) tick();

        // Stalled load, then act_valid held during compute (must be ignored)
        rom_basic();
        clear_scores();
        act_valid = 1'b0;
        load_frame(1, 16'sd1);
        act_valid = 1'b1;
        for (int i = 0; i < FRAME - 20; i++) begin
            act_data = 16'($urandom);
            tick();
        end
        act_valid = 1'b0;
        wait_done();
        check("lit_stall_7", dut_score[7], 70);
        check("lit_stall_9", dut_score[9], 90);

        // Reset during neuron 4 accumulation
        rom_random();
        load_frame(2, 16'sd0);
        begin
            int t = 0;
            while (!(out_valid && out_index == 4'd3) && t < FRAME) begin
                tick();
                t++;
            end
            check("mid_strobe_timeout", t < FRAME, 1);
        end
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Fresh frame after reset
        rom_random();
        load_frame(3, 16'sd0);
        wait_done();

        // Back-to-back frames loaded straight after frame_done
        rom_random();
        load_frame(2, 16'sd0);
        for (int f = 0; f < 3; f++) begin
            wait_done();
            load_frame(2, 16'sd0);
        end
        wait_done();
        repeat (4) tick();

        check("frames_completed", frames_done, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
